// File: rtl/serial_adder_pkg.sv
// Shared types for the chunk-serial adder.
// FSM encoding and a counter-width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/serial_chunk_adder_chunk.sv
// One W-bit slice of the serial adder.
// Also reports the carry into the slice MSB for overflow.
module chunk_adder #(
  parameter int W = 2
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         co_o,
  output logic         cmsb_o
);

  logic [W:0] full;

  assign full   = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};
  assign s_o    = full[W-1:0];
  assign co_o   = full[W];
  // sum bit = a ^ b ^ cin, so cin is recovered from it
  assign cmsb_o = full[W-1] ^ a_i[W-1] ^ b_i[W-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// Chunk-serial add/subtract, one W-bit slice per cycle.
// Valid/ready on both sides; one operation in flight.
module serial_chunk_adder
  import serial_adder_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int CHUNKS = (W < 1) ? 1 : N / W;
  localparam int CW     = cnt_w(CHUNKS);

  generate
    if (W < 1) begin : g_bad_w
      $error("serial_chunk_adder: W must be >= 1");
    end else if (N % W != 0) begin : g_bad_n
      $error("serial_chunk_adder: N must be a multiple of W");
    end
  endgenerate

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  res_q, res_d;
  logic [N-1:0]  sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [W-1:0]  ca, cb, cs;
  logic          cco, ccm, last;
  int            base;

  always_comb begin
    base = int'(cnt_q) * W;
    ca   = a_q[base +: W];
    cb   = b_q[base +: W];
    last = (cnt_q == CW'(CHUNKS - 1));
  end

  chunk_adder #(.W(W)) u_chunk (
    .a_i    (ca),
    .b_i    (cb),
    .c_i    (carry_q),
    .s_o    (cs),
    .co_o   (cco),
    .cmsb_o (ccm)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // subtract is a + ~b + 1, borrow-in folds into the carry
          a_d     = a;
          b_d     = b ^ {N{sub}};
          carry_d = cin ^ sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[base +: W] = cs;
        carry_d = cco;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          sum_d   = res_d;
          cout_d  = cco;
          ovf_d   = ccm ^ cco;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Bench for serial_chunk_adder: three configurations,
// checked against a signed/unsigned arithmetic model.
module tb_serial_chunk_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int          sel = 0;
  logic [15:0] a_s = '0, b_s = '0;
  logic        cin_s = 0, sub_s = 0;
  logic        in_valid_s = 0, out_ready_s = 0;

  logic iv0, iv1, iv2;
  assign iv0 = in_valid_s && (sel == 0);
  assign iv1 = in_valid_s && (sel == 1);
  assign iv2 = in_valid_s && (sel == 2);

  logic ir0, ov0, co0, of0;
  logic ir1, ov1, co1, of1;
  logic ir2, ov2, co2, of2;
  logic [7:0]  s0, s2;
  logic [15:0] s1;

  serial_chunk_adder #(.N(8), .W(2)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv0), .in_ready(ir0),
    .a(a_s[7:0]), .b(b_s[7:0]),
    .cin(cin_s), .sub(sub_s),
    .out_valid(ov0), .out_ready(out_ready_s),
    .sum(s0), .cout(co0), .ovf(of0)
  );

  serial_chunk_adder #(.N(16), .W(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1),
    .a(a_s), .b(b_s),
    .cin(cin_s), .sub(sub_s),
    .out_valid(ov1), .out_ready(out_ready_s),
    .sum(s1), .cout(co1), .ovf(of1)
  );

  serial_chunk_adder #(.N(8), .W(8)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv2), .in_ready(ir2),
    .a(a_s[7:0]), .b(b_s[7:0]),
    .cin(cin_s), .sub(sub_s),
    .out_valid(ov2), .out_ready(out_ready_s),
    .sum(s2), .cout(co2), .ovf(of2)
  );

  logic        ir_m, ov_m, co_m, of_m;
  logic [15:0] sum_m;

  always_comb begin
    ir_m = ir0; ov_m = ov0; co_m = co0; of_m = of0;
    sum_m = {8'h00, s0};
    case (sel)
      1: begin
        ir_m = ir1; ov_m = ov1; co_m = co1; of_m = of1;
        sum_m = s1;
      end
      2: begin
        ir_m = ir2; ov_m = ov2; co_m = co2; of_m = of2;
        sum_m = {8'h00, s2};
      end
      default: ;
    endcase
  end

  int nvec = 0;
  int errs = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          pending = 0;
  bit          seen = 0;
  int          accept_cyc = 0;
  logic [15:0] exp_sum = '0;
  logic        exp_co = 0, exp_ov = 0;

  function automatic int nof(input int s);
    return (s == 1) ? 16 : 8;
  endfunction

  function automatic int chunks_of(input int s);
    return (s == 2) ? 1 : 4;
  endfunction

  // {ovf, cout, sum} from plain unsigned and signed arithmetic
  function automatic logic [17:0] model(input int n, input logic [15:0] av,
                                        input logic [15:0] bv,
                                        input logic ci, input logic sb);
    longint unsigned mod, ua, ub, r;
    longint sa, sbv, sr, lo, hi;
    logic co, ov;
    mod = 64'd1 << n;
    ua  = av & (mod - 1);
    ub  = bv & (mod - 1);
    sa  = (ua >= mod / 2) ? longint'(ua) - longint'(mod) : longint'(ua);
    sbv = (ub >= mod / 2) ? longint'(ub) - longint'(mod) : longint'(ub);
    if (!sb) begin
      r  = ua + ub + ci;
      co = (r >= mod);
      sr = sa + sbv + ci;
    end else begin
      co = (ua >= ub + ci);
      r  = ua - ub - ci;
      sr = sa - sbv - ci;
    end
    r  = r & (mod - 1);
    lo = -longint'(mod / 2);
    hi = longint'(mod / 2) - 1;
    ov = (sr < lo) || (sr > hi);
    return {ov, co, r[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [17:0] act,
                     input logic [17:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ov_m) begin
      if (!pending) begin
        nvec++;
        errs++;
        $display("FAIL spurious_valid: got out_valid=1, want 0 (t=%0t)", $time);
      end else begin
        if (!seen) begin
          seen = 1;
          chk("latency", 18'(cyc - accept_cyc), 18'(chunks_of(sel)));
        end
        chk("sum", {2'b00, sum_m}, {2'b00, exp_sum});
        chk("cout", {17'b0, co_m}, {17'b0, exp_co});
        chk("ovf", {17'b0, of_m}, {17'b0, exp_ov});
        chk("in_ready_busy", {17'b0, ir_m}, 18'd0);
      end
    end
  end

  task automatic do_op(input int s, input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, input logic sb, input int hold,
                       input bit rnd);
    logic [17:0] m;
    int k, held;
    bit done;
    @(negedge clk);
    sel = s; a_s = av; b_s = bv; cin_s = ci; sub_s = sb;
    in_valid_s = 1; out_ready_s = 0;
    chk("in_ready_idle", {17'b0, ir_m}, 18'd1);
    m = model(nof(s), av, bv, ci, sb);
    @(posedge clk); #1;
    accept_cyc = cyc;
    exp_sum = m[15:0]; exp_co = m[16]; exp_ov = m[17];
    seen = 0; pending = 1;
    in_valid_s = (hold > 0);
    held = 0; done = 0; k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
      if (ov_m) begin
        if (rnd) out_ready_s = 1'($urandom_range(0, 1));
        else out_ready_s = (held >= hold);
        held++;
        if (out_ready_s) begin
          in_valid_s = 0;
          @(posedge clk); #1;
          pending = 0; done = 1;
          chk("release_valid", {17'b0, ov_m}, 18'd0);
          chk("release_ready", {17'b0, ir_m}, 18'd1);
          chk("sum_held", {2'b00, sum_m}, {2'b00, exp_sum});
          out_ready_s = 0;
        end
      end else begin
        out_ready_s = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    if (!done) begin
      nvec++;
      errs++;
      $display("FAIL timeout: got no handshake in 100 cycles, want one (sel=%0d)", s);
      pending = 0; in_valid_s = 0; out_ready_s = 0;
    end
  endtask

  logic [17:0] m;
  logic [15:0] ra, rb;

  initial begin
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk("rst_sum", {2'b00, sum_m}, 18'd0);
      chk("rst_flags", {15'b0, co_m, of_m, ov_m}, 18'd0);
      chk("rst_ready", {17'b0, ir_m}, 18'd1);
    end
    sel = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    m = model(8, 16'hFF, 16'h01, 0, 0);
    chk("model_ff_01", m, {1'b0, 1'b1, 16'h0000});
    do_op(0, 16'hFF, 16'h01, 0, 0, 0, 0);
    m = model(8, 16'h7F, 16'h01, 0, 0);
    chk("model_7f_01", m, {1'b1, 1'b0, 16'h0080});
    do_op(0, 16'h7F, 16'h01, 0, 0, 0, 0);
    m = model(8, 16'h05, 16'h07, 0, 1);
    chk("model_05_sub_07", m, {1'b0, 1'b0, 16'h00FE});
    do_op(0, 16'h05, 16'h07, 0, 1, 0, 0);
    m = model(8, 16'h00, 16'h00, 1, 1);
    chk("model_00_sub_borrow", m, {1'b0, 1'b0, 16'h00FF});
    do_op(0, 16'h00, 16'h00, 1, 1, 0, 0);
    m = model(8, 16'h80, 16'h00, 1, 1);
    chk("model_80_sub_borrow", m, {1'b1, 1'b1, 16'h007F});
    do_op(0, 16'h80, 16'h00, 1, 1, 0, 0);

    do_op(0, 16'h12, 16'h34, 1, 0, 3, 0);

    @(negedge clk);
    sel = 0; a_s = 16'h33; b_s = 16'h44; cin_s = 0; sub_s = 0;
    in_valid_s = 1;
    @(posedge clk); #1;
    in_valid_s = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 0; #1;
    chk("abort_sum", {2'b00, sum_m}, 18'd0);
    chk("abort_flags", {15'b0, co_m, of_m, ov_m}, 18'd0);
    chk("abort_ready", {17'b0, ir_m}, 18'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    m = model(8, 16'h10, 16'h20, 0, 0);
    chk("model_10_20", m, {2'b00, 16'h0030});
    do_op(0, 16'h10, 16'h20, 0, 0, 0, 0);

    for (int s = 1; s < 3; s++) begin
      for (int i = 0; i < 200; i++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        if (s == 2) begin
          ra[15:8] = 8'h00;
          rb[15:8] = 8'h00;
        end
        do_op(s, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              0, 1);
      end
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule

// File: doc/serial_chunk_adder.md
SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

Interface
REQ-001 SHALL have parameter N, default 8: operand width in bits.
REQ-002 SHALL have parameter W, default 2: chunk width processed per cycle.
REQ-003 SHALL have port clk, input, 1: the single clock; all flops on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: operands and mode presented.
REQ-006 SHALL have port in_ready, output, 1: block can accept an operation.
REQ-007 SHALL have port a, input, N: operand A.
REQ-008 SHALL have port b, input, N: operand B.
REQ-009 SHALL have port cin, input, 1: carry-in (add) or borrow-in (subtract).
REQ-010 SHALL have port sub, input, 1: 0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid, output, 1: result is valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port sum, output, N: result.
REQ-014 SHALL have port cout, output, 1: final carry out of the MSB.
REQ-015 SHALL have port ovf, output, 1: two's-complement overflow.

Function
REQ-016 SHALL reject any configuration with N % W != 0 or W < 1 at elaboration; CHUNKS = N/W.
REQ-017 SHALL implement an FSM with states IDLE, RUN and DONE; in_ready = (state == IDLE).
REQ-018 SHALL accept an operation on a rising edge in IDLE with in_valid=1, latching a, b xor {N{sub}}, and initial carry = cin xor sub, then entering RUN.
REQ-019 SHALL, in RUN, add one W-bit chunk per cycle, LSB chunk first, propagating the carry between chunks in a registered carry flop.
REQ-020 SHALL assert out_valid exactly CHUNKS cycles after the accepting edge, entering DONE.
REQ-021 SHALL set sum = (a + b + cin) mod 2^N when sub=0, and (a - b - cin) mod 2^N when sub=1.
REQ-022 SHALL set cout = carry out of bit N-1; for subtract, cout=1 means no borrow.
REQ-023 SHALL set ovf = carry into bit N-1 xor carry out of bit N-1, captured from the final chunk.
REQ-024 SHALL hold sum, cout, ovf and out_valid stable in DONE while out_ready=0.
REQ-025 SHALL return to IDLE on the edge where out_valid=1 and out_ready=1, clearing out_valid.
REQ-026 SHALL ignore in_valid in RUN and DONE; there is no overlap between operations.
REQ-027 SHALL, when W = N, spend exactly one cycle in RUN.
REQ-028 SHALL leave sum, cout and ovf unchanged outside DONE until the next result is written.

Reset
REQ-029 SHALL, while rst_n=0, force state=IDLE, out_valid=0, sum=0, cout=0, ovf=0, and clear the internal operand, carry and chunk-count registers.
REQ-030 SHALL abort any operation in RUN or DONE on reset; no out_valid is produced for it.
REQ-031 SHALL accept a new operation on the first rising edge after rst_n deasserts.

Structure
REQ-032 SHALL place the state enum typedef in the shared package serial_adder_pkg.
REQ-033 SHALL use one combinational sub-module, chunk_adder, parameterised by W, with outputs chunk sum, carry out, and carry into the chunk MSB.

Verification
REQ-034 SHALL check, with N=8 and W=2, that a=FF, b=01, cin=0, sub=0 yields sum=00, cout=1, ovf=0, with out_valid asserted exactly 4 cycles after acceptance.
REQ-035 SHALL check that a=7F, b=01, cin=0, sub=0 yields sum=80, cout=0, ovf=1.
REQ-036 SHALL check that a=05, b=07, cin=0, sub=1 yields sum=FE, cout=0, ovf=0; and that a=00, b=00, cin=1, sub=1 yields sum=FF, cout=0.
REQ-037 SHALL check that holding out_ready=0 for 3 cycles in DONE keeps sum/cout/ovf stable and in_ready=0 with in_valid=1 ignored, and that raising out_ready returns the block to IDLE on the next edge.
REQ-038 SHALL check that rst_n pulsed low after 2 chunks in RUN zeroes all outputs, that no out_valid appears for the aborted operation, and that the next operation (a=10, b=20) yields sum=30.
REQ-039 SHALL run N=16, W=4 and N=8, W=8 with 200 random vectors each against a reference model, checking sum, cout and ovf, latency CHUNKS, and random out_ready backpressure.
